// File: rtl/div_ctrl.sv
// ----------------------------------------------------------------------------
// div_ctrl
//   Multi-cycle radix-2 restoring divider and controller for the EX stage.
//   It accepts one DIV/MOD request and holds EX through stallreq_o while it
//   iterates. It then returns the quotient and remainder together with a
//   one-cycle ready_o pulse.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   start_i      request, sampled only while idle
//   annul_i      flush, aborts any operation in progress
//   signed_i     1 = two's-complement signed divide, 0 = unsigned
//   opdata1_i    dividend, sampled with start_i
//   opdata2_i    divisor, sampled with start_i
//   quotient_o   quotient, valid with ready_o, held until the next result
//   remainder_o  remainder, same validity as quotient_o
//   ready_o      one-cycle result-valid pulse
//   stallreq_o   combinational stall request to pipeline control
// ----------------------------------------------------------------------------
module div_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] opdata1_i,
    input  logic [DATA_WIDTH-1:0] opdata2_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int unsigned           CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] dvd_q;     // dividend shifts out of the top while quotient bits shift in
    logic [DATA_WIDTH-1:0] rem;       // partial remainder
    logic [DATA_WIDTH-1:0] dvs;       // divisor magnitude
    logic [DATA_WIDTH-1:0] op1_raw;   // original dividend, returned as remainder on divide-by-zero
    logic                  neg_q;
    logic                  neg_r;

    // Operand magnitudes at request time
    logic                  op1_neg;
    logic                  op2_neg;
    logic [DATA_WIDTH-1:0] op1_mag;
    logic [DATA_WIDTH-1:0] op2_mag;

    always_comb begin
        op1_neg = signed_i & opdata1_i[DATA_WIDTH-1];
        op2_neg = signed_i & opdata2_i[DATA_WIDTH-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;
    end

    // One restoring step. The extra top bit of the subtract acts as the borrow,
    // so the partial remainder can never overflow.
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic                  qbit;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] q_next;
    logic [DATA_WIDTH-1:0] q_final;
    logic [DATA_WIDTH-1:0] r_final;

    always_comb begin
        shifted  = {rem, dvd_q[DATA_WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        qbit     = ~diff[DATA_WIDTH];
        rem_next = qbit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        q_next   = {dvd_q[DATA_WIDTH-2:0], qbit};
        q_final  = neg_q ? -q_next   : q_next;
        r_final  = neg_r ? -rem_next : rem_next;
    end

    // Outputs are registered on the edge that enters END, so the sign fix-up is
    // applied to the last iteration's values and the result is already present
    // while END is the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dvd_q       <= '0;
            rem         <= '0;
            dvs         <= '0;
            op1_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            ready_o     <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i && (state != S_IDLE)) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i && !annul_i) begin
                            op1_raw <= opdata1_i;
                            if (opdata2_i == '0) begin
                                state <= S_DIVZERO;
                            end else begin
                                dvd_q <= op1_mag;
                                dvs   <= op2_mag;
                                rem   <= '0;
                                cnt   <= '0;
                                neg_q <= op1_neg ^ op2_neg;
                                neg_r <= op1_neg;
                                state <= S_ON;
                            end
                        end
                    end
                    S_DIVZERO: begin
                        quotient_o  <= '1;
                        remainder_o <= op1_raw;
                        ready_o     <= 1'b1;
                        state       <= S_END;
                    end
                    S_ON: begin
                        dvd_q <= q_next;
                        rem   <= rem_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            quotient_o  <= q_final;
                            remainder_o <= r_final;
                            ready_o     <= 1'b1;
                            state       <= S_END;
                        end
                    end
                    S_END: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign stallreq_o = rst & (((state == S_IDLE) & start_i & ~annul_i) |
                               (state == S_ON) | (state == S_DIVZERO));

endmodule
